// File: rtl/bit_serial_adder.sv
// -----------------------------------------------------------------------------
// bit_serial_adder
//
// Multi-cycle WIDTH-bit adder built from a single full-adder cell. One bit is
// processed per clock, LSB first. The carry out of each bit is registered and
// fed into the next bit. A start/busy/done handshake frames each operation.
// A new result is produced every WIDTH+2 cycles.
//
// Optional feature macro: SERIAL_SUB_EN
//   When defined, a 'sub' port is added. Asserting sub on the accepting edge
//   computes a-b: the module loads ~b and forces the initial carry to 1.
//   In that mode cout=1 means "no borrow" (a >= b).
//   When undefined, the module adds only and has no inverter on b.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset
//   start  in   1      operation request, sampled only while idle
//   a      in   WIDTH  operand A, captured on the accepting edge
//   b      in   WIDTH  operand B, captured on the accepting edge
//   cin    in   1      carry-in, captured on the accepting edge
//   sub    in   1      (SERIAL_SUB_EN only) 1 = subtract
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse when out/cout become valid
//   out    out  WIDTH  result, held until the next completed operation
//   cout   out  1      final carry, held together with out
// -----------------------------------------------------------------------------
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   areg_q,  areg_d;
    logic [WIDTH-1:0]   breg_q,  breg_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    // Only WIDTH-1 sum bits need storing: the last bit goes straight into out.
    logic [WIDTH-2:0]   sum_q,   sum_d;
    logic [WIDTH-1:0]   out_q,   out_d;
    logic               cout_q,  cout_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    // Operand values loaded on the accepting edge.
    logic [WIDTH-1:0]   b_load;
    logic               carry_load;

`ifdef SERIAL_SUB_EN
    // a - b == a + ~b + 1; cin is ignored when subtracting.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    logic               bit_s;
    logic               bit_c;
    logic [WIDTH-1:0]   shifted;

    always_comb begin
        state_d = state_q;
        areg_d  = areg_q;
        breg_d  = breg_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        out_d   = out_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = done_q;

        // The single full-adder cell.
        bit_s   = areg_q[0] ^ breg_q[0] ^ carry_q;
        bit_c   = (areg_q[0] & breg_q[0]) | (areg_q[0] & carry_q) | (breg_q[0] & carry_q);
        // New bit enters at the MSB; after WIDTH steps bit 0 sits at the LSB.
        shifted = {bit_s, sum_q};

        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    areg_d  = a;
                    breg_d  = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                areg_d  = areg_q >> 1;
                breg_d  = breg_q >> 1;
                sum_d   = shifted[WIDTH-1:1];
                carry_d = bit_c;
                if (cnt_q == LAST_BIT) begin
                    // Counter is left alone here so it never wraps.
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    out_d   = shifted;
                    cout_d  = bit_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            areg_q  <= '0;
            breg_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            areg_q  <= areg_d;
            breg_q  <= breg_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_adder
//
// Self-checking bench for bit_serial_adder (WIDTH=8). Expected results are
// queued when an operation is started and compared when done pulses.
// Define SERIAL_SUB_EN to also exercise subtraction.
// -----------------------------------------------------------------------------
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SERIAL_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         cout;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .out   (out),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    logic [W:0] exp_q[$];
    logic [W:0] exp_v;
    int         checks = 0;
    int         errors = 0;

    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
        if (ms) return {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
        return {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding result.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got out=%h cout=%b with no result outstanding", out, cout);
            end else begin
                exp_v = exp_q.pop_front();
                if ({cout, out} !== exp_v) begin
                    errors++;
                    $display("FAIL result: got cout=%b out=%h expected cout=%b out=%h",
                             cout, out, exp_v[W], exp_v[W-1:0]);
                end
            end
        end
    end

    task automatic drive_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic tc, input logic ts);
        a   = ta;
        b   = tb_v;
        cin = tc;
`ifdef SERIAL_SUB_EN
        sub = ts;
`endif
        start = 1'b1;
        exp_q.push_back(model(ta, tb_v, tc, ts));
    endtask

    // Starts one operation from IDLE and waits for done; reports busy length.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic ts, output int busy_cycles);
        int n;
        @(negedge clk);
        drive_op(ta, tb_v, tc, ts);
        @(negedge clk);
        start = 1'b0;
        a = ~ta;
        b = ~tb_v;
        cin = ~tc;
        busy_cycles = 0;
        n = 0;
        while (done !== 1'b1 && n < 3 * W) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: got done=%b after %0d cycles expected 1", done, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
`ifdef SERIAL_SUB_EN
        sub = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b1;
            checks++;
            if ({busy, done, cout, out} !== '0) begin
                errors++;
                $display("FAIL reset_hold: got busy=%b done=%b cout=%b out=%h expected all 0",
                         busy, done, cout, out);
            end
        end
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, cout, out} !== '0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b done=%b cout=%b out=%h expected all 0",
                     busy, done, cout, out);
        end
    endtask

    task automatic test_basic();
        int bc;
        run_op(8'h5A, 8'h33, 1'b0, 1'b0, bc);
        checks++;
        if (bc != W) begin
            errors++;
            $display("FAIL busy_length: got %0d expected %0d", bc, W);
        end
        checks++;
        if ({cout, out} !== {1'b0, 8'h8D}) begin
            errors++;
            $display("FAIL basic_sum: got cout=%b out=%h expected cout=0 out=8d", cout, out);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_done: got %b expected 0", busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || {cout, out} !== {1'b0, 8'h8D}) begin
            errors++;
            $display("FAIL done_pulse_hold: got done=%b out=%h expected done=0 out=8d", done, out);
        end
    endtask

    task automatic test_carry_edges();
        int bc;
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, bc);
        checks++;
        if ({cout, out} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL wrap_ff_01: got cout=%b out=%h expected cout=1 out=00", cout, out);
        end
        run_op(8'hFF, 8'h00, 1'b1, 1'b0, bc);
        checks++;
        if ({cout, out} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL wrap_ff_cin: got cout=%b out=%h expected cout=1 out=00", cout, out);
        end
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, bc);
        checks++;
        if ({cout, out} !== {1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL max_sum: got cout=%b out=%h expected cout=1 out=ff", cout, out);
        end
    endtask

    task automatic test_ignore_start();
        int n;
        int dones;
        @(negedge clk);
        drive_op(8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        // Mid-RUN request with different operands must be dropped.
        a = 8'hAA;
        b = 8'hBB;
        cin = 1'b1;
        start = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_mid_run: got %b expected 1", busy);
        end
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 3 * W) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({done, cout, out} !== {1'b1, 1'b0, 8'h46}) begin
            errors++;
            $display("FAIL ignore_start_result: got done=%b cout=%b out=%h expected 1 0 46",
                     done, cout, out);
        end
        dones = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL ignore_start_no_second: got %0d active cycles expected 0", dones);
        end
    endtask

    task automatic test_reset_mid_run();
        int bc;
        @(negedge clk);
        drive_op(8'h5A, 8'h33, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, cout, out} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b cout=%b out=%h expected all 0",
                     busy, done, cout, out);
        end
        run_op(8'h01, 8'h02, 1'b1, 1'b0, bc);
        checks++;
        if ({cout, out} !== {1'b0, 8'h04} || bc != W) begin
            errors++;
            $display("FAIL after_reset_op: got cout=%b out=%h busy=%0d expected 0 04 %0d",
                     cout, out, bc, W);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int d1;
        int d2;
        int dones;
        @(negedge clk);
        drive_op(8'hC3, 8'h5C, 1'b1, 1'b0);
        @(negedge clk);
        // Operands change while the first op runs; start stays high.
        drive_op(8'h81, 8'h90, 1'b0, 1'b0);
        cyc = 0;
        dones = 0;
        d1 = -1;
        d2 = -1;
        while (dones < 2 && cyc < 4 * (W + 2)) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                dones++;
                if (dones == 1) d1 = cyc;
                else d2 = cyc;
            end
            if (dones == 1 && busy === 1'b1) start = 1'b0;
        end
        start = 1'b0;
        checks++;
        if (dones != 2 || (d2 - d1) != W + 2) begin
            errors++;
            $display("FAIL back_to_back: got %0d dones spacing %0d expected 2 spacing %0d",
                     dones, d2 - d1, W + 2);
        end
        checks++;
        if ({cout, out} !== {1'b1, 8'h11}) begin
            errors++;
            $display("FAIL back_to_back_second: got cout=%b out=%h expected cout=1 out=11", cout, out);
        end
    endtask

    task automatic test_random();
        int bc;
        for (int i = 0; i < 300; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, bc);
    endtask

`ifdef SERIAL_SUB_EN
    task automatic test_sub();
        int bc;
        run_op(8'h10, 8'h01, 1'b0, 1'b1, bc);
        checks++;
        if ({cout, out} !== {1'b1, 8'h0F}) begin
            errors++;
            $display("FAIL sub_10_01: got cout=%b out=%h expected cout=1 out=0f", cout, out);
        end
        run_op(8'h00, 8'h01, 1'b1, 1'b1, bc);
        checks++;
        if ({cout, out} !== {1'b0, 8'hFF}) begin
            errors++;
            $display("FAIL sub_00_01: got cout=%b out=%h expected cout=0 out=ff", cout, out);
        end
        for (int i = 0; i < 1000; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), bc);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry_edges();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
`ifdef SERIAL_SUB_EN
        test_sub();
`endif
        for (int i = 0; i < 4; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL outstanding: got %0d results never produced expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
